// File: rtl/scan_afficheur4.sv
// Time-multiplexed 4-digit seven-segment scanner with a double-buffered display value.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module scan_afficheur4 #(
    parameter int unsigned REFRESH_DIV      = 50000,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Value,
    input  logic        Load,
    output logic [3:0]  Nibble,
    output logic [3:0]  Digit_En,
    output logic        Frame
);

    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] disp_q, disp_d;
    logic        active_q, active_d;
    logic [3:0]  nibble_q, nibble_d;
    logic [3:0]  en_q, en_d;
    logic        frame_q, frame_d;
    logic        tick;
    logic        wrap;

    function automatic logic [3:0] digit_nibble(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        n = v[{i, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // A digit blanks only when it and every more significant digit are zero.
        case (i)
            2'd1:    if (v[15:4] == '0)  n = '1;
            2'd2:    if (v[15:8] == '0)  n = '1;
            2'd3:    if (v[15:12] == '0) n = '1;
            default: ;
        endcase
`endif
        return n;
    endfunction

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        wrap      = tick && (idx_q == 2'd3);
        presc_d   = tick ? '0 : presc_q + 16'd1;
        idx_d     = idx_q;
        pending_d = Load ? Value : pending_q;
        disp_d    = disp_q;
        active_d  = active_q;
        nibble_d  = nibble_q;
        en_d      = en_q;
        frame_d   = 1'b0;
        if (tick) begin
            idx_d    = idx_q + 2'd1;
            active_d = 1'b1;
            // A load on the wrap edge bypasses pending so it shows without a frame of delay.
            if (wrap) begin
                disp_d  = Load ? Value : pending_q;
                frame_d = 1'b1;
            end
            nibble_d = digit_nibble(disp_d, idx_d);
            en_d     = 4'b0001 << idx_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q   <= '0;
            idx_q     <= 2'd3;
            pending_q <= '0;
            disp_q    <= '0;
            active_q  <= 1'b0;
            nibble_q  <= '0;
            en_q      <= '0;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            disp_q    <= disp_d;
            active_q  <= active_d;
            nibble_q  <= nibble_d;
            en_q      <= en_d;
            frame_q   <= frame_d;
        end
    end

    assign Nibble   = nibble_q;
    assign Frame    = frame_q;
    assign Digit_En = DIGIT_ACTIVE_LOW ? ~(active_q ? en_q : 4'b0000)
                                       :  (active_q ? en_q : 4'b0000);

endmodule

// File: tb/tb_scan_afficheur4.sv
// Scoreboard bench for scan_afficheur4: expected (cycle, nibble, enables, frame) entries are
// queued with the stimulus and compared when the bench's edge counter reaches that cycle.
module tb_scan_afficheur4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Value;
    logic        Load;
    logic [3:0]  Nibble;
    logic [3:0]  Digit_En;
    logic        Frame;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  nib;
        logic [3:0]  en;
        logic        fr;
    } exp_t;

    exp_t sb[$];
    exp_t e;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BLK = 4'hF;
`else
    localparam logic [3:0] BLK = 4'h0;
`endif

    scan_afficheur4 #(
        .REFRESH_DIV     (4),
        .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Value   (Value),
        .Load    (Load),
        .Nibble  (Nibble),
        .Digit_En(Digit_En),
        .Frame   (Frame)
    );

    always #5 Clk = ~Clk;

    // Edge 1 is the first rising edge with Reset low.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned c, input logic [3:0] nib,
                             input logic [3:0] en, input logic fr);
        exp_t x;
        x.cyc = c; x.nib = nib; x.en = en; x.fr = fr;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int unsigned n);
        for (int unsigned k = 0; k < 500 && cyc < n; k++) begin
            @(posedge Clk);
            #2;
        end
        if (cyc < n) chk("wait_timeout", 16'(cyc), 16'(n));
    endtask

    task automatic load_at(input int unsigned n, input logic [15:0] v);
        wait_cyc(n - 1);
        Value = v;
        Load  = 1'b1;
        wait_cyc(n);
        Load  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},  16'(Digit_En), 16'hF);
        chk({tag, "_nib"}, 16'(Nibble),   16'h0);
        chk({tag, "_fr"},  16'(Frame),    16'h0);
    endtask

    always @(posedge Clk) begin
        #1;
        if (!Reset) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    chk("missed_entry", 16'(cyc), 16'(e.cyc));
                end else begin
                    chk("nibble", 16'(Nibble),   16'(e.nib));
                    chk("digen",  16'(Digit_En), 16'(e.en));
                    chk("frame",  16'(Frame),    16'(e.fr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        Load  = 1'b0;
        Value = '0;
        repeat (2) @(posedge Clk);
        #2;
        chk_reset_outputs("por");

        // Idle after reset: nothing shows before the first tick, pending is zero.
        expect_at(3, 4'h0, 4'b1111, 1'b0);
        expect_at(4, 4'h0, 4'b1110, 1'b1);
        expect_at(5, 4'h0, 4'b1110, 1'b0);
        expect_at(8, 4'h0, 4'b1101, 1'b0);
        Reset = 1'b0;
        wait_cyc(9);

        #1 Reset = 1'b1;
        #1 chk_reset_outputs("rst2");
        @(posedge Clk);
        #2;

        // Load 1234 at edge 2, then a scan through all digits and a wrap.
        expect_at(4,  4'h4, 4'b1110, 1'b1);
        expect_at(8,  4'h3, 4'b1101, 1'b0);
        expect_at(12, 4'h2, 4'b1011, 1'b0);
        expect_at(16, 4'h1, 4'b0111, 1'b0);
        expect_at(20, 4'h4, 4'b1110, 1'b1);
        // Mid-frame loads while digit 1 is on: current frame unaffected, last load wins.
        expect_at(28, 4'h2, 4'b1011, 1'b0);
        expect_at(32, 4'h1, 4'b0111, 1'b0);
        expect_at(36, 4'hD, 4'b1110, 1'b1);
        expect_at(40, 4'hC, 4'b1101, 1'b0);
        expect_at(44, 4'hB, 4'b1011, 1'b0);
        expect_at(48, 4'hA, 4'b0111, 1'b0);
        // Load on the wrap edge bypasses pending.
        expect_at(52, 4'h8, 4'b1110, 1'b1);
        expect_at(53, 4'h8, 4'b1110, 1'b0);
        expect_at(56, 4'h7, 4'b1101, 1'b0);
        // Leading-zero handling of 0050 and 0000.
        expect_at(68, 4'h0, 4'b1110, 1'b1);
        expect_at(72, 4'h5, 4'b1101, 1'b0);
        expect_at(76, BLK,  4'b1011, 1'b0);
        expect_at(80, BLK,  4'b0111, 1'b0);
        expect_at(84, 4'h0, 4'b1110, 1'b1);
        expect_at(88, BLK,  4'b1101, 1'b0);
        expect_at(92, BLK,  4'b1011, 1'b0);
        Reset = 1'b0;

        load_at(2,  16'h1234);
        load_at(25, 16'h9999);
        load_at(26, 16'hABCD);
        load_at(52, 16'h5678);
        load_at(60, 16'h0050);
        load_at(82, 16'h0000);
        load_at(90, 16'h4321);

        // Reset between edges while digit 2 is on; the pending 4321 must be lost.
        wait_cyc(93);
        #1 Reset = 1'b1;
        #1 chk_reset_outputs("midscan");
        chk("sb_drained", 16'(sb.size()), 16'd0);
        @(posedge Clk);
        #2;
        expect_at(3, 4'h0, 4'b1111, 1'b0);
        expect_at(4, 4'h0, 4'b1110, 1'b1);
        expect_at(8, 4'h0, 4'b1101, 1'b0);
        Reset = 1'b0;
        wait_cyc(9);
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
